// File: rtl/ram_portb_arbiter.sv
// ram_portb_arbiter: shares port B of the dual-port ram between the scalar
// LSU (single accesses) and the vector LSU (strided bursts whose element
// addresses are generated here). All ram_* outputs are registered; the ram
// returns read data one cycle after an access is presented.
// Optional build macro VEC_YIELD_EN: lets a waiting scalar access slip into
// a running vector burst every YIELD_INTERVAL elements.
//
// Handshake: s_req / v_req are held high by the requester until the matching
// s_gnt / v_gnt pulse; the grant cycle is the transfer cycle (request fields
// are sampled at the clock edge that ends it), so a request counts as
// accepted exactly when req && gnt, and the requester may drop or change it
// in the following cycle.
module ram_portb_arbiter #(
  parameter int ADDR_W         = 17,
  parameter int DATA_W         = 32,
  parameter int LEN_W          = 8,
  parameter int YIELD_INTERVAL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_req,
  input  logic              s_we,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              s_gnt,
  output logic              s_rvalid,
  output logic [DATA_W-1:0] s_rdata,
  input  logic              v_req,
  input  logic              v_we,
  input  logic [ADDR_W-1:0] v_base,
  input  logic [ADDR_W-1:0] v_stride,
  input  logic [LEN_W-1:0]  v_len,
  output logic              v_gnt,
  output logic [LEN_W-1:0]  v_idx,
  output logic              v_wnext,
  input  logic [DATA_W-1:0] v_wdata,
  output logic              v_rvalid,
  output logic [LEN_W-1:0]  v_ridx,
  output logic [DATA_W-1:0] v_rdata,
  output logic              v_done,
  output logic              ram_we_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_din_b,
  input  logic [DATA_W-1:0] ram_dout_b
);

`ifdef VEC_YIELD_EN
  localparam bit YIELD_ON = 1'b1;
`else
  localparam bit YIELD_ON = 1'b0;
`endif
  localparam int              YW        = $clog2(YIELD_INTERVAL + 1);
  localparam logic [YW-1:0]   YIELD_MAX = YW'(YIELD_INTERVAL);
  localparam logic [YW-1:0]   Y_ONE     = YW'(1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  typedef enum logic [1:0] {IDLE, VRUN, VDRAIN} state_t;

  state_t              state_q, state_d;
  logic                prio_q, prio_d;     // 0: scalar wins a tie, 1: vector
  logic                s_gnt_c, v_gnt_c, issue_s, issue_v, last_el, yield_now;
  logic                bw_q;               // latched burst direction
  logic [LEN_W-1:0]    blen_q, cnt_q;
  logic [ADDR_W-1:0]   stride_q, acc_q;
  logic [YW-1:0]       ycnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   din_q;
  logic                p1_s_q, p1_v_q, s_rv_q, v_rv_q, done_q;
  logic [LEN_W-1:0]    p1_idx_q, ridx_q;

  assign last_el   = (cnt_q == blen_q - LEN_ONE);
  assign yield_now = YIELD_ON && (ycnt_q == YIELD_MAX) && s_req;

  // Arbitration and burst sequencing: next state, grants and issue strobes.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    s_gnt_c = 1'b0;
    v_gnt_c = 1'b0;
    issue_s = 1'b0;
    issue_v = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (s_req && (!v_req || !prio_q)) begin
            s_gnt_c = 1'b1;
            issue_s = 1'b1;
            if (v_req) prio_d = 1'b1;
          end else if (v_req) begin
            v_gnt_c = 1'b1;
            if (s_req) prio_d = 1'b0;
            if (v_len != '0) state_d = VRUN;
          end
        end
        VRUN: begin
          if (yield_now) begin
            s_gnt_c = 1'b1;
            issue_s = 1'b1;
          end else begin
            issue_v = 1'b1;
            if (last_el) state_d = VDRAIN;
          end
        end
        // Last element is on ram_* now; its data/completion follow next cycle.
        VDRAIN: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register and round-robin priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  // Burst context: latched on grant, address accumulates by stride per element.
  always_ff @(posedge clk) begin
    if (rst) begin
      bw_q     <= 1'b0;
      blen_q   <= '0;
      stride_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (v_gnt_c) begin
      bw_q     <= v_we;
      blen_q   <= v_len;
      stride_q <= v_stride;
      acc_q    <= v_base;
      cnt_q    <= '0;
    end else if (issue_v) begin
      acc_q <= acc_q + stride_q;
      cnt_q <= cnt_q + LEN_ONE;
    end
  end

  // Elements issued since the last scalar slot (only consulted with VEC_YIELD_EN).
  always_ff @(posedge clk) begin
    if (rst || v_gnt_c || (issue_s && state_q == VRUN)) ycnt_q <= '0;
    else if (issue_v) ycnt_q <= (ycnt_q == YIELD_MAX) ? Y_ONE : ycnt_q + Y_ONE;
  end

  // Registered RAM port B; address and data hold when nothing is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else if (issue_s) begin
      we_q   <= s_we;
      addr_q <= s_addr;
      din_q  <= s_wdata;
    end else if (issue_v) begin
      we_q   <= bw_q;
      addr_q <= acc_q;
      if (bw_q) din_q <= v_wdata;
    end else begin
      we_q <= 1'b0;
    end
  end

  // Two-stage read tags (issue -> on ram_* -> data back) and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_s_q   <= 1'b0;
      p1_v_q   <= 1'b0;
      p1_idx_q <= '0;
      s_rv_q   <= 1'b0;
      v_rv_q   <= 1'b0;
      ridx_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      p1_s_q   <= issue_s && !s_we;
      p1_v_q   <= issue_v && !bw_q;
      p1_idx_q <= cnt_q;
      s_rv_q   <= p1_s_q;
      v_rv_q   <= p1_v_q;
      ridx_q   <= p1_idx_q;
      done_q   <= (v_gnt_c && v_len == '0) || (state_q == VDRAIN);
    end
  end

  assign s_gnt      = s_gnt_c;
  assign v_gnt      = v_gnt_c;
  assign v_idx      = (state_q == VRUN) ? cnt_q : '0;
  assign v_wnext    = issue_v && bw_q;
  assign s_rvalid   = s_rv_q;
  assign s_rdata    = s_rv_q ? ram_dout_b : '0;
  assign v_rvalid   = v_rv_q;
  assign v_ridx     = ridx_q;
  assign v_rdata    = v_rv_q ? ram_dout_b : '0;
  assign v_done     = done_q;
  assign ram_we_b   = we_q;
  assign ram_addr_b = addr_q;
  assign ram_din_b  = din_q;

endmodule

// File: tb/tb_ram_portb_arbiter.sv
// Directed bench for ram_portb_arbiter with a behavioural registered-read RAM,
// a shadow memory model and cycle-stamped expectation queues.
module tb_ram_portb_arbiter;
  localparam int AW = 17;
  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_req, s_we, s_gnt, s_rvalid;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic          v_req, v_we, v_gnt, v_wnext, v_rvalid, v_done;
  logic [AW-1:0] v_base, v_stride;
  logic [LW-1:0] v_len, v_idx, v_ridx;
  logic [DW-1:0] v_wdata, v_rdata;
  logic          ram_we_b;
  logic [AW-1:0] ram_addr_b;
  logic [DW-1:0] ram_din_b, ram_dout_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural RAM port B: registered read, dout holds on write
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [DW-1:0] poke_data = '0;
  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
    else ram_dout_b <= mem[ram_addr_b];
  end

  logic [DW-1:0] wdata_base = '0;
  assign v_wdata = wdata_base + DW'(v_idx);

  ram_portb_arbiter dut (
    .clk(clk), .rst(rst),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .v_req(v_req), .v_we(v_we), .v_base(v_base), .v_stride(v_stride),
    .v_len(v_len), .v_gnt(v_gnt), .v_idx(v_idx), .v_wnext(v_wnext),
    .v_wdata(v_wdata), .v_rvalid(v_rvalid), .v_ridx(v_ridx),
    .v_rdata(v_rdata), .v_done(v_done),
    .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_din_b(ram_din_b),
    .ram_dout_b(ram_dout_b)
  );

  // scoreboard: expected events stamped with the cycle they must appear in
  logic [63:0]   exp_s_q[$];   // {cycle, data}
  logic [71:0]   exp_v_q[$];   // {cycle, idx, data}
  logic [80:0]   exp_w_q[$];   // {cycle, addr, data}
  logic [31:0]   exp_d_q[$];   // cycle
  logic [DW-1:0] model [logic [AW-1:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor_loop();
    logic [63:0] es;
    logic [71:0] ev;
    logic [80:0] ew;
    logic [31:0] ed;
    forever begin
      @(negedge clk);
      if (s_rvalid) begin
        if (exp_s_q.size() == 0) chk("s_rvalid_unexpected", 32'(s_rvalid), 32'd0);
        else begin
          es = exp_s_q.pop_front();
          chk("s_rvalid_cycle", cyc, es[63:32]);
          chk("s_rdata", s_rdata, es[31:0]);
        end
      end
      if (v_rvalid) begin
        if (exp_v_q.size() == 0) chk("v_rvalid_unexpected", 32'(v_rvalid), 32'd0);
        else begin
          ev = exp_v_q.pop_front();
          chk("v_rvalid_cycle", cyc, ev[71:40]);
          chk("v_ridx", 32'(v_ridx), 32'(ev[39:32]));
          chk("v_rdata", v_rdata, ev[31:0]);
        end
      end
      if (ram_we_b) begin
        if (exp_w_q.size() == 0) chk("ram_write_unexpected", 32'(ram_we_b), 32'd0);
        else begin
          ew = exp_w_q.pop_front();
          chk("ram_write_cycle", cyc, ew[80:49]);
          chk("ram_addr_b", 32'(ram_addr_b), 32'(ew[48:32]));
          chk("ram_din_b", ram_din_b, ew[31:0]);
        end
      end
      if (v_done) begin
        if (exp_d_q.size() == 0) chk("v_done_unexpected", 32'(v_done), 32'd0);
        else begin
          ed = exp_d_q.pop_front();
          chk("v_done_cycle", cyc, ed);
        end
      end
    end
  endtask

  // driver tasks
  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, 32'({s_gnt, v_gnt, ram_we_b, s_rvalid, v_rvalid, v_done, v_wnext}), 32'd0);
    chk({tag, "_addr"}, 32'(ram_addr_b), 32'd0);
    chk({tag, "_din"}, ram_din_b, 32'd0);
    chk({tag, "_idx"}, 32'({v_idx, v_ridx}), 32'd0);
    chk({tag, "_rdata"}, s_rdata | v_rdata, 32'd0);
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    poke_en = 1'b1; poke_addr = a; poke_data = d; model[a] = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_s_q.size() + exp_v_q.size() + exp_w_q.size() + exp_d_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_pending", 32'(exp_s_q.size() + exp_v_q.size() + exp_w_q.size() + exp_d_q.size()), 32'd0);
  endtask

  task automatic scalar_acc(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got = 1'b0;
    @(posedge clk); #1;
    s_req = 1'b1; s_we = we; s_addr = a; s_wdata = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_gnt) begin got = 1'b1; break; end
    end
    chk("s_gnt_seen", 32'(got), 32'd1);
    if (got) begin
      if (we) begin
        exp_w_q.push_back({32'(cyc + 1), a, d});
        model[a] = d;
      end else begin
        exp_s_q.push_back({32'(cyc + 2), model[a]});
      end
    end
    @(posedge clk); #1;
    s_req = 1'b0;
  endtask

  task automatic vec_burst(input logic we, input logic [AW-1:0] base, input logic [AW-1:0] stride,
                           input logic [LW-1:0] len, input logic [DW-1:0] wb, input bit full,
                           output int g);
    bit got = 1'b0;
    logic [AW-1:0] a;
    @(posedge clk); #1;
    v_req = 1'b1; v_we = we; v_base = base; v_stride = stride; v_len = len; wdata_base = wb;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (v_gnt) begin got = 1'b1; break; end
    end
    chk("v_gnt_seen", 32'(got), 32'd1);
    g = cyc;
    a = base;
    if (got) begin
      for (int i = 0; i < int'(len); i++) begin
        if (we) begin
          exp_w_q.push_back({32'(g + 2 + i), a, wb + 32'(i)});
          model[a] = wb + 32'(i);
        end else if (full || i == 0) begin
          exp_v_q.push_back({32'(g + 3 + i), 8'(i), model[a]});
        end
        a = a + stride;
      end
      if (full) exp_d_q.push_back(32'(g + ((len == '0) ? 1 : int'(len) + 2)));
    end
    @(posedge clk); #1;
    v_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_req = 1'b0; v_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int g;
    int c0;
    bit got;
    rst = 1'b1;
    s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
    v_req = 1'b0; v_we = 1'b0; v_base = '0; v_stride = '0; v_len = '0;
    fork monitor_loop(); join_none

    do_reset();

    // scalar read/write
    poke(17'h10, 32'hDEADBEEF);
    poke(17'h10C, 32'h5A5A0003);
    scalar_acc(1'b0, 17'h10, '0);
    scalar_acc(1'b1, 17'h20, 32'h12345678);
    scalar_acc(1'b0, 17'h20, '0);
    drain();

    // vector store then load of the same burst
    vec_burst(1'b1, 17'h100, 17'd4, 8'd3, 32'hA0, 1'b1, g);
    drain();
    vec_burst(1'b0, 17'h100, 17'd4, 8'd3, 32'h0, 1'b1, g);
    drain();

    // address wrap and negative stride
    vec_burst(1'b1, 17'h1FFFF, 17'h00001, 8'd2, 32'hB0, 1'b1, g);
    drain();
    poke(17'h2, 32'hC2);
    poke(17'h1, 32'hC1);
    vec_burst(1'b0, 17'h2, 17'h1FFFF, 8'd3, 32'h0, 1'b1, g);
    drain();
    vec_burst(1'b1, 17'h2, 17'h1FFFF, 8'd3, 32'hD0, 1'b1, g);
    drain();

    // zero-length bursts
    vec_burst(1'b1, 17'h300, 17'd1, 8'd0, 32'hE0, 1'b1, g);
    vec_burst(1'b0, 17'h300, 17'd1, 8'd0, 32'h0, 1'b1, g);
    repeat (4) @(negedge clk);
    drain();

    // random scalar traffic over a block written by a unit-stride burst
    vec_burst(1'b1, 17'h200, 17'd1, 8'd8, 32'h300, 1'b1, g);
    drain();
    for (int i = 0; i < 10; i++) begin
      scalar_acc(1'($urandom_range(1, 0)), 17'h200 + 17'($urandom_range(7, 0)), $urandom);
    end
    vec_burst(1'b0, 17'h200, 17'd1, 8'd8, 32'h0, 1'b1, g);
    drain();

    // contention from reset: scalar first, vector next, scalar re-request waits
    do_reset();
    @(posedge clk); #1;
    s_req = 1'b1; s_we = 1'b0; s_addr = 17'h10;
    v_req = 1'b1; v_we = 1'b0; v_base = 17'h100; v_stride = 17'd4; v_len = 8'd4;
    @(negedge clk);
    chk("contend_first_s_gnt", 32'(s_gnt), 32'd1);
    chk("contend_first_v_gnt", 32'(v_gnt), 32'd0);
    if (s_gnt) exp_s_q.push_back({32'(cyc + 2), model[17'h10]});
    @(posedge clk); #1;
    s_addr = 17'h20;
    @(negedge clk);
    chk("contend_second_v_gnt", 32'(v_gnt), 32'd1);
    chk("contend_second_s_gnt", 32'(s_gnt), 32'd0);
    g = cyc;
    if (v_gnt) begin
      for (int i = 0; i < 4; i++)
        exp_v_q.push_back({32'(g + 3 + i), 8'(i), model[17'h100 + 17'(4 * i)]});
      exp_d_q.push_back(32'(g + 6));
    end
    @(posedge clk); #1;
    v_req = 1'b0;
    got = 1'b0;
    c0 = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_gnt) begin got = 1'b1; c0 = cyc; break; end
    end
    chk("contend_rereq_gnt_cycle", c0, g + 6);
    chk("contend_rereq_with_done", 32'(v_done), 32'd1);
    if (got) exp_s_q.push_back({32'(cyc + 2), model[17'h20]});
    @(posedge clk); #1;
    s_req = 1'b0;
    drain();

    // reset in the middle of a load burst
    vec_burst(1'b0, 17'h100, 17'd4, 8'd5, 32'h0, 1'b0, g);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (v_idx == 8'd2) begin got = 1'b1; break; end
    end
    chk("midrst_elem2_cycle", cyc, got ? g + 3 : -1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    scalar_acc(1'b0, 17'h10, '0);
    drain();
    repeat (5) @(negedge clk);
    chk("final_v_q_empty", 32'(exp_v_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_portb_arbiter.md
Name: ram_portb_arbiter

Overview:
- Sequences and shares the read/write port B of the dual-port `ram` between two requesters: the scalar load/store unit (single accesses) and the vector load/store unit (strided bursts).
- For vector bursts it generates the element addresses itself.
- Port A (instruction fetch) is untouched.
- Sits between both LSUs and `ram`; all RAM-side outputs are registered.

Parameters:
- ADDR_W, 17, RAM address width; must match `RAM_ADDR_WID`.
- DATA_W, 32, RAM data width; must match `RAM_DATA_WID`.
- LEN_W, 8, width of the vector element count (max burst 2^LEN_W-1).
- YIELD_INTERVAL, 4, vector elements between scalar slots; used only with VEC_YIELD_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_req  in  1  scalar request; held until s_gnt
- s_we  in  1  scalar write (1) / read (0)
- s_addr  in  ADDR_W  scalar address
- s_wdata  in  DATA_W  scalar write data
- s_gnt  out  1  1-cycle pulse: scalar request accepted this cycle
- s_rvalid  out  1  scalar read data valid
- s_rdata  out  DATA_W  scalar read data (= ram_dout_b)
- v_req  in  1  vector burst request; held until v_gnt
- v_we  in  1  burst is store (1) / load (0)
- v_base  in  ADDR_W  first element address
- v_stride  in  ADDR_W  address increment per element (two's complement, modulo 2^ADDR_W)
- v_len  in  LEN_W  element count
- v_gnt  out  1  1-cycle pulse: burst accepted, fields sampled
- v_idx  out  LEN_W  index of element issued this cycle
- v_wnext  out  1  store element v_idx is consumed this cycle
- v_wdata  in  DATA_W  store data for element v_idx; combinational from requester
- v_rvalid  out  1  load element data valid
- v_ridx  out  LEN_W  index of returned element
- v_rdata  out  DATA_W  load data (= ram_dout_b)
- v_done  out  1  1-cycle pulse: burst complete
- ram_we_b  out  1  to ram we_b
- ram_addr_b  out  ADDR_W  to ram addr_b
- ram_din_b  out  DATA_W  to ram din_b
- ram_dout_b  in  DATA_W  from ram dout_b

Behaviour:
- Reset: all outputs 0; FSM to IDLE; rr_prio = scalar; in-flight read tags cleared, so no rvalid follows a reset, even mid-burst.
- States:
  - IDLE: arbitration.
  - VRUN: issuing burst elements.
  - VDRAIN: waiting for the last load data.
- RAM timing: ram is registered-read. An access placed on ram_* in cycle T returns data on ram_dout_b in cycle T+1. On a write, dout_b holds its old value.
- Scalar access:
  - s_gnt in cycle G.
  - ram_* driven in G+1; ram_we_b=s_we.
  - For a read, s_rvalid=1 in G+2.
  - Writes produce no s_rvalid.
  - A scalar requester may be re-granted every cycle (throughput 1/cycle).
- Arbitration (in IDLE, or the cycle after a scalar grant):
  - Only one requester: grant it.
  - Both requesting: grant rr_prio's owner, then flip rr_prio.
  - A scalar grant with v_req pending sets rr_prio=vector.
- Burst acceptance:
  - On v_gnt, latch base, stride, len and we.
  - len==0: v_done pulses the next cycle, no RAM access, return to IDLE.
  - Otherwise enter VRUN.
- VRUN:
  - Element i (0..len-1) is placed on ram_* in consecutive cycles.
  - Address = base + i*stride, computed by running accumulation, wraps modulo 2^ADDR_W.
  - Store: v_wnext=1 and v_idx=i in the cycle before element i reaches ram_*; v_wdata is registered into ram_din_b then.
  - Load: v_rvalid, v_ridx=i one cycle after element i is on ram_*.
  - Bursts are not preemptible (without the optional feature).
- End of burst:
  - Store: v_done one cycle after the last element is on ram_*; then IDLE.
  - Load: enter VDRAIN; v_done coincides with the last v_rvalid; then IDLE.
  - A new grant may be issued in the v_done cycle.
- Requests asserted during VRUN/VDRAIN wait; s_req is not dropped or reordered.
- ram_we_b=0 whenever no access is issued; ram_addr_b holds its last value.

Optional Feature:
- Macro: VEC_YIELD_EN.
- Defined:
  - During VRUN, after every YIELD_INTERVAL issued vector elements, if s_req is high, one scalar access is slotted in (s_gnt pulses; the burst stalls 1 cycle; v_idx/v_wnext hold).
  - Element order and addresses are unchanged.
- Undefined: scalar waits for full burst completion.

Test Plan:
- Scalar read: preload ram[0x10]=0xDEADBEEF; s_req, s_addr=0x10 -> s_gnt cycle G, s_rvalid at G+2 with s_rdata=0xDEADBEEF.
- Vector store then load: base=0x100, stride=4, len=3, wdata=idx+0xA0, then load the same burst -> ram[0x100/0x104/0x108]=0xA0/0xA1/0xA2; v_rvalid on 3 consecutive cycles, ridx 0,1,2; v_done with the last rvalid.
- Wrap and negative stride: base=0x1FFFF, stride=0x00001, len=2 -> addresses 0x1FFFF, 0x00000; a second burst with base=0x2, stride=0x1FFFF (-1), len=3 -> addresses 2, 1, 0.
- Contention: s_req and v_req both high from reset -> scalar granted first; the vector burst is granted next; a scalar re-request waits until v_done. With VEC_YIELD_EN and len=8, the scalar access is slotted after element 3; total burst time is 9 cycles.
- len=0 burst -> v_gnt, v_done the next cycle, ram_we_b never 1, no v_rvalid.
- Reset mid-load-burst (len=5, rst at element 2) -> all outputs 0 the next cycle, no further v_rvalid/v_done, FSM in IDLE; a fresh scalar read succeeds afterwards.
